fu_completion_unit: RTL and testbench
=====================================

# fu_completion_unit

Execution-side counterpart of the reservation station. It accepts the one-per-cycle issue stream (`ready`, packet, FU index), and tracks each occupied functional-unit slot through a fixed per-class latency. It then retires completed slots by driving the single CDB broadcast (`update`, `ready_reg` tag) and one-cycle `free_*` pulses back to the reservation station. It sits between the reservation-station issue port and the CDB/free inputs of the same station.

## Interface
- `NUM_ALU`, 2, number of ALU slots
- `NUM_MULT`, 2, number of MULT slots
- `NUM_LOAD`, 1, number of LOAD slots
- `NUM_STORE`, 1, number of STORE slots
- `NUM_BRANCH`, 1, number of BRANCH slots
- `ALU_LAT` / `MULT_LAT` / `LOAD_LAT` / `STORE_LAT` / `BRANCH_LAT`, 1/4/2/1/1, cycles from issue to completion-eligible; each ≥1
- `TAG_W`, 6, physical-register tag width
- Reset and clock (already decided): reset reset, synchronous, active-high; clock clock.
- `clock`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `issue_valid`  in  1  issue strobe (RS `ready`)
- `issue_funit`  in  FUNIT  class of issued op (ALU/MULT/LOAD/STORE/BRANCH)
- `issue_fu_index`  in  `MAX_FU_INDEX`  slot within class
- `issue_tag`  in  TAG_W  destination preg tag
- `issue_has_dest`  in  1  op writes a register
- `flush`  in  1  squash all in-flight ops
- `cdb_valid`  out  1  CDB broadcast (RS `update`)
- `cdb_tag`  out  TAG_W  broadcast tag (RS `ready_reg`)
- `free_alu` / `free_mult` / `free_load` / `free_store` / `free_branch`  out  NUM_x each  one-cycle slot-free pulses
- `inflight`  out  $clog2(total+1)  number of busy slots
- `protocol_err`  out  1  sticky illegal-issue flag

## Operation
- Per slot: `busy`, down-counter, `tag`, `has_dest`. Slots are flattened in the order ALU0..n, MULT0..n, LOAD, STORE, BRANCH for arbitration.
- Issue: on `issue_valid` with a legal, non-busy slot, load `busy`=1, counter=LAT-1, tag, and has_dest.
- Illegal issue sets `protocol_err`; the issue is ignored. Illegal means the index is ≥ the class count, or the target slot is busy (including a slot being retired on the same edge).
- Each edge, a busy slot with counter>0 decrements. A slot is pending when busy and counter==0.
- Pending with has_dest=0: retired unconditionally on the next edge. Any number of these may retire at once; they assert free only, with no CDB.
- Pending with has_dest=1: a round-robin arbiter grants one per cycle. The search starts at `rr_ptr`, and the first pending-with-dest slot wins. On grant: the slot is cleared, `cdb_valid`=1, `cdb_tag`=slot tag, the matching free bit is pulsed, and `rr_ptr` ← grant+1 (wrapping to 0 past the last slot). `rr_ptr` is unchanged when there is no grant.
- Losing pending slots hold (the counter stays at 0) until granted.
- Issue and retire of different slots on the same edge are both honoured.
- `flush`: all slots are cleared, and the next cycle's `cdb_valid` and free outputs are 0. `rr_ptr` is held. An `issue_valid` on the same edge is dropped and does not raise an error. `protocol_err` is not cleared.
- `inflight` is the registered popcount of `busy` after the edge's updates.

## Timing
- All outputs are registered.
- Reset values: `cdb_valid`=0, `cdb_tag`=0, all `free_*`=0, `inflight`=0, `protocol_err`=0. Internally, all slots are idle and `rr_ptr`=0.
- Reset has priority over flush, issue, and retire. Reset mid-operation discards all in-flight ops, with no CDB or free pulse.
- Issue sampled at edge t → earliest `cdb_valid`/free observed in the cycle starting at edge t+LAT. Example: ALU_LAT=1 gives a visible result one cycle after the issue edge.
- `cdb_valid` and `free_*` are one-cycle pulses. The freed slot is issuable in the same cycle that its free pulse is visible.
- Throughput: at most one CDB broadcast per cycle. Free pulses for has_dest=0 slots may coincide with a CDB pulse.

## Test plan
- Reset, then ALU0 issue of tag 5 at edge 1 → `cdb_valid`=1, `cdb_tag`=5, and `free_alu`=2'b01 in the cycle after edge 2. All outputs are 0 the following cycle, and `inflight` goes 1 then 0.
- MULT0 issue of tag 9 at edge 1, then ALU1 issue of tag 3 at edge 4 → both are pending at edge 5. The grant goes to ALU1 (rr_ptr=0, lowest flattened index), so tag 3 is visible after edge 5 and tag 9 after edge 6. `rr_ptr` ends at 3 (after MULT0).
- Two ALUs and one MULT all pending, repeated twice → grant order rotates per round-robin, no slot is starved, and each free bit pulses exactly once.
- STORE issue with has_dest=0 and ALU0 issue with tag 7 at the same completion edge → `free_store`=1 and the CDB tag 7 with `free_alu`=2'b01 appear in the same cycle.
- Re-issue to busy ALU0, and issue to ALU index 2 → `protocol_err`=1 and stays 1. The original ALU0 op still completes with its own tag.
- MULT in flight with counter 2, then `flush` → no CDB or free pulse ever appears for it, and `inflight`=0. A new MULT0 issue the next cycle is accepted without error.

Source files
------------

// File: rtl/fu_completion_unit.sv
// Completion side of the reservation station: tracks each functional-unit slot through its
// class latency, then retires slots with one CDB broadcast per cycle plus free pulses.
module fu_completion_unit #(
  parameter int NUM_ALU    = 2,
  parameter int NUM_MULT   = 2,
  parameter int NUM_LOAD   = 1,
  parameter int NUM_STORE  = 1,
  parameter int NUM_BRANCH = 1,
  parameter int ALU_LAT    = 1,
  parameter int MULT_LAT   = 4,
  parameter int LOAD_LAT   = 2,
  parameter int STORE_LAT  = 1,
  parameter int BRANCH_LAT = 1,
  parameter int TAG_W      = 6,
  parameter int FU_IDX_W   = 2,
  localparam int N         = NUM_ALU + NUM_MULT + NUM_LOAD + NUM_STORE + NUM_BRANCH,
  localparam int INF_W     = $clog2(N + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_issue_valid,
  input  logic [2:0]            i_issue_funit,
  input  logic [FU_IDX_W-1:0]   i_issue_fu_index,
  input  logic [TAG_W-1:0]      i_issue_tag,
  input  logic                  i_issue_has_dest,
  input  logic                  i_flush,
  output logic                  o_cdb_valid,
  output logic [TAG_W-1:0]      o_cdb_tag,
  output logic [NUM_ALU-1:0]    o_free_alu,
  output logic [NUM_MULT-1:0]   o_free_mult,
  output logic [NUM_LOAD-1:0]   o_free_load,
  output logic [NUM_STORE-1:0]  o_free_store,
  output logic [NUM_BRANCH-1:0] o_free_branch,
  output logic [INF_W-1:0]      o_inflight,
  output logic                  o_protocol_err
);

  localparam int OFF_MULT   = NUM_ALU;
  localparam int OFF_LOAD   = OFF_MULT + NUM_MULT;
  localparam int OFF_STORE  = OFF_LOAD + NUM_LOAD;
  localparam int OFF_BRANCH = OFF_STORE + NUM_STORE;
  localparam int MAX_LAT_A  = (ALU_LAT > MULT_LAT) ? ALU_LAT : MULT_LAT;
  localparam int MAX_LAT_B  = (LOAD_LAT > STORE_LAT) ? LOAD_LAT : STORE_LAT;
  localparam int MAX_LAT_C  = (MAX_LAT_A > MAX_LAT_B) ? MAX_LAT_A : MAX_LAT_B;
  localparam int MAX_LAT    = (MAX_LAT_C > BRANCH_LAT) ? MAX_LAT_C : BRANCH_LAT;
  localparam int CNT_W      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
  localparam int SLOT_W     = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] FU_ALU    = 3'd0;
  localparam logic [2:0] FU_MULT   = 3'd1;
  localparam logic [2:0] FU_LOAD   = 3'd2;
  localparam logic [2:0] FU_STORE  = 3'd3;
  localparam logic [2:0] FU_BRANCH = 3'd4;

  logic [N-1:0]      r_busy;
  logic [N-1:0]      r_has_dest;
  logic [CNT_W-1:0]  r_cnt [N];
  logic [TAG_W-1:0]  r_tag [N];
  logic [SLOT_W-1:0] r_rr_ptr;
  logic [N-1:0]      r_free;

  logic [N-1:0]      w_pend;
  logic [N-1:0]      w_pend_dest;
  logic [N-1:0]      w_grant;
  logic [N-1:0]      w_retire;
  logic [N-1:0]      w_issue_onehot;
  logic [N-1:0]      w_busy_next;
  logic              w_grant_any;
  logic [SLOT_W-1:0] w_grant_idx;
  int                w_base;
  int                w_count;
  logic [CNT_W-1:0]  w_lat_m1;
  logic              w_idx_ok;
  logic [SLOT_W-1:0] w_slot;
  logic              w_issue_ok;
  logic              w_issue_err;

  function automatic logic [INF_W-1:0] popcnt(input logic [N-1:0] v);
    logic [INF_W-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s = s + INF_W'(v[i]);
    return s;
  endfunction

  always_comb begin
    for (int i = 0; i < N; i++) w_pend[i] = r_busy[i] && (r_cnt[i] == '0);
  end

  assign w_pend_dest = w_pend & r_has_dest;

  // Rotating priority: first pending-with-dest slot at or after r_rr_ptr wins.
  always_comb begin
    w_grant     = '0;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = int'(r_rr_ptr) + k;
      if (j >= N) j = j - N;
      if (!w_grant_any && w_pend_dest[j]) begin
        w_grant_any = 1'b1;
        w_grant_idx = SLOT_W'(j);
        w_grant[j]  = 1'b1;
      end
    end
  end

  assign w_retire = (w_pend & ~r_has_dest) | w_grant;

  always_comb begin
    w_base   = 0;
    w_count  = 0;
    w_lat_m1 = '0;
    case (i_issue_funit)
      FU_ALU:    begin w_base = 0;          w_count = NUM_ALU;    w_lat_m1 = CNT_W'(ALU_LAT - 1);    end
      FU_MULT:   begin w_base = OFF_MULT;   w_count = NUM_MULT;   w_lat_m1 = CNT_W'(MULT_LAT - 1);   end
      FU_LOAD:   begin w_base = OFF_LOAD;   w_count = NUM_LOAD;   w_lat_m1 = CNT_W'(LOAD_LAT - 1);   end
      FU_STORE:  begin w_base = OFF_STORE;  w_count = NUM_STORE;  w_lat_m1 = CNT_W'(STORE_LAT - 1);  end
      FU_BRANCH: begin w_base = OFF_BRANCH; w_count = NUM_BRANCH; w_lat_m1 = CNT_W'(BRANCH_LAT - 1); end
      default:   begin w_base = 0;          w_count = 0;          w_lat_m1 = '0;                     end
    endcase
    w_idx_ok = int'(i_issue_fu_index) < w_count;
    w_slot   = w_idx_ok ? SLOT_W'(w_base + int'(i_issue_fu_index)) : '0;
    // A slot retiring on this edge is still busy, so re-issuing to it is an error.
    w_issue_ok  = i_issue_valid && w_idx_ok && !r_busy[w_slot];
    w_issue_err = i_issue_valid && !w_issue_ok;
    w_issue_onehot = '0;
    if (w_issue_ok) w_issue_onehot[w_slot] = 1'b1;
    w_busy_next = (r_busy & ~w_retire) | w_issue_onehot;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_busy         <= '0;
      r_has_dest     <= '0;
      r_rr_ptr       <= '0;
      r_free         <= '0;
      o_cdb_valid    <= 1'b0;
      o_cdb_tag      <= '0;
      o_inflight     <= '0;
      o_protocol_err <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
        r_tag[i] <= '0;
      end
    end else if (i_flush) begin
      r_busy      <= '0;
      r_free      <= '0;
      o_cdb_valid <= 1'b0;
      o_cdb_tag   <= '0;
      o_inflight  <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (r_busy[i] && r_cnt[i] != '0) r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
      if (w_issue_ok) begin
        r_cnt[w_slot]      <= w_lat_m1;
        r_tag[w_slot]      <= i_issue_tag;
        r_has_dest[w_slot] <= i_issue_has_dest;
      end
      r_busy      <= w_busy_next;
      r_free      <= w_retire;
      o_cdb_valid <= w_grant_any;
      o_cdb_tag   <= w_grant_any ? r_tag[w_grant_idx] : '0;
      o_inflight  <= popcnt(w_busy_next);
      if (w_grant_any)
        r_rr_ptr <= (w_grant_idx == SLOT_W'(N - 1)) ? '0 : w_grant_idx + SLOT_W'(1);
      if (w_issue_err) o_protocol_err <= 1'b1;
    end
  end

  assign o_free_alu    = r_free[OFF_MULT-1:0];
  assign o_free_mult   = r_free[OFF_LOAD-1:OFF_MULT];
  assign o_free_load   = r_free[OFF_STORE-1:OFF_LOAD];
  assign o_free_store  = r_free[OFF_BRANCH-1:OFF_STORE];
  assign o_free_branch = r_free[N-1:OFF_BRANCH];

endmodule

// File: tb/tb_fu_completion_unit.sv
// Bench for fu_completion_unit: directed scenarios plus random traffic, all compared
// cycle by cycle against a slot-table model that tracks absolute ready times.
module tb_fu_completion_unit;

  logic       clock;
  logic       reset;
  logic       i_issue_valid;
  logic [2:0] i_issue_funit;
  logic [1:0] i_issue_fu_index;
  logic [5:0] i_issue_tag;
  logic       i_issue_has_dest;
  logic       i_flush;
  logic       o_cdb_valid;
  logic [5:0] o_cdb_tag;
  logic [1:0] o_free_alu;
  logic [1:0] o_free_mult;
  logic       o_free_load;
  logic       o_free_store;
  logic       o_free_branch;
  logic [2:0] o_inflight;
  logic       o_protocol_err;
  logic [6:0] free_all;

  fu_completion_unit dut (
    .clock            (clock),
    .reset            (reset),
    .i_issue_valid    (i_issue_valid),
    .i_issue_funit    (i_issue_funit),
    .i_issue_fu_index (i_issue_fu_index),
    .i_issue_tag      (i_issue_tag),
    .i_issue_has_dest (i_issue_has_dest),
    .i_flush          (i_flush),
    .o_cdb_valid      (o_cdb_valid),
    .o_cdb_tag        (o_cdb_tag),
    .o_free_alu       (o_free_alu),
    .o_free_mult      (o_free_mult),
    .o_free_load      (o_free_load),
    .o_free_store     (o_free_store),
    .o_free_branch    (o_free_branch),
    .o_inflight       (o_inflight),
    .o_protocol_err   (o_protocol_err)
  );

  assign free_all = {o_free_branch, o_free_store, o_free_load, o_free_mult, o_free_alu};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk_val(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Reference model: each slot remembers the edge number at which it becomes eligible.
  typedef struct {
    bit busy;
    int ready_at;
    int tag;
    bit dest;
  } slot_t;

  slot_t m_slot [7];
  int cls_base [5] = '{0, 2, 4, 5, 6};
  int cls_cnt  [5] = '{2, 2, 1, 1, 1};
  int cls_lat  [5] = '{1, 4, 2, 1, 1};
  int m_rr     = 0;
  int edge_n   = 0;
  int e_valid  = 0;
  int e_tag    = 0;
  int e_free   = 0;
  int e_infl   = 0;
  int e_err    = 0;

  task automatic model_edge(input bit v, input int fu, input int idx, input int tag,
                            input bit dest, input bit fl, input bit rst);
    bit legal;
    int gslot;
    int s;
    edge_n++;
    e_valid = 0; e_tag = 0; e_free = 0;
    if (rst) begin
      foreach (m_slot[i]) m_slot[i].busy = 0;
      m_rr = 0; e_infl = 0; e_err = 0;
      return;
    end
    if (fl) begin
      foreach (m_slot[i]) m_slot[i].busy = 0;
      e_infl = 0;
      return;
    end
    legal = v && fu < 5 && idx < cls_cnt[fu < 5 ? fu : 0];
    if (legal) legal = !m_slot[cls_base[fu] + idx].busy;
    if (v && !legal) e_err = 1;
    gslot = -1;
    for (int k = 0; k < 7; k++) begin
      s = (m_rr + k) % 7;
      if (gslot < 0 && m_slot[s].busy && m_slot[s].dest && edge_n >= m_slot[s].ready_at)
        gslot = s;
    end
    for (int i = 0; i < 7; i++) begin
      if (m_slot[i].busy && !m_slot[i].dest && edge_n >= m_slot[i].ready_at) begin
        e_free |= (1 << i);
        m_slot[i].busy = 0;
      end
    end
    if (gslot >= 0) begin
      e_valid = 1;
      e_tag   = m_slot[gslot].tag;
      e_free |= (1 << gslot);
      m_slot[gslot].busy = 0;
      m_rr = (gslot + 1) % 7;
    end
    if (legal) begin
      s = cls_base[fu] + idx;
      m_slot[s].busy     = 1;
      m_slot[s].ready_at = edge_n + cls_lat[fu];
      m_slot[s].tag      = tag;
      m_slot[s].dest     = dest;
    end
    e_infl = 0;
    foreach (m_slot[i]) if (m_slot[i].busy) e_infl++;
  endtask

  task automatic step(input bit v, input int fu, input int idx, input int tag,
                      input bit dest, input bit fl, input bit rst);
    reset            = rst;
    i_issue_valid    = v;
    i_issue_funit    = 3'(fu);
    i_issue_fu_index = 2'(idx);
    i_issue_tag      = 6'(tag);
    i_issue_has_dest = dest;
    i_flush          = fl;
    @(posedge clock);
    model_edge(v, fu, idx, tag, dest, fl, rst);
    #1;
    chk_val("cdb_valid", int'(o_cdb_valid), e_valid);
    chk_val("cdb_tag", int'(o_cdb_tag), e_tag);
    chk_val("free", int'(free_all), e_free);
    chk_val("inflight", int'(o_inflight), e_infl);
    chk_val("protocol_err", int'(o_protocol_err), e_err);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b1; i_issue_valid = 1'b0; i_issue_funit = '0; i_issue_fu_index = '0;
    i_issue_tag = '0; i_issue_has_dest = 1'b0; i_flush = 1'b0;

    do_reset();
    chk_val("reset_cdb", int'(o_cdb_valid), 0);
    chk_val("reset_infl", int'(o_inflight), 0);

    // ALU0 tag 5: result one cycle after issue
    step(1, 0, 0, 5, 1, 0, 0);
    chk_val("s1_infl_one", int'(o_inflight), 1);
    idle();
    chk_val("s1_cdb_valid", int'(o_cdb_valid), 1);
    chk_val("s1_tag", int'(o_cdb_tag), 5);
    chk_val("s1_free_alu", int'(o_free_alu), 1);
    chk_val("s1_infl_zero", int'(o_inflight), 0);
    idle();
    chk_val("s1_quiet", int'(o_cdb_valid), 0);

    // MULT0 tag 9 and ALU1 tag 3 pending together; lowest index wins first
    do_reset();
    step(1, 1, 0, 9, 1, 0, 0);
    idle(); idle();
    step(1, 0, 1, 3, 1, 0, 0);
    idle();
    chk_val("s2_first_tag", int'(o_cdb_tag), 3);
    chk_val("s2_first_free", int'(o_free_alu), 2);
    idle();
    chk_val("s2_second_tag", int'(o_cdb_tag), 9);
    chk_val("s2_second_free", int'(o_free_mult), 1);

    // Contention rounds
    do_reset();
    for (int r = 0; r < 2; r++) begin
      step(1, 1, 0, 10 + r, 1, 0, 0);
      step(1, 1, 1, 20 + r, 1, 0, 0);
      step(1, 0, 0, 30 + r, 1, 0, 0);
      step(1, 0, 1, 40 + r, 1, 0, 0);
      for (int k = 0; k < 8; k++) idle();
    end

    // STORE without dest retires alongside a CDB grant for ALU0
    do_reset();
    step(1, 0, 1, 1, 1, 0, 0);
    step(1, 1, 0, 2, 1, 0, 0);
    idle(); idle();
    step(1, 0, 0, 7, 1, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0);
    chk_val("s4_mult_tag", int'(o_cdb_tag), 2);
    idle();
    chk_val("s4_alu_tag", int'(o_cdb_tag), 7);
    chk_val("s4_free_mix", int'(free_all), 33);

    // Illegal issues
    do_reset();
    step(1, 0, 0, 11, 1, 0, 0);
    step(1, 0, 0, 12, 1, 0, 0);
    chk_val("s5_err_busy", int'(o_protocol_err), 1);
    chk_val("s5_orig_tag", int'(o_cdb_tag), 11);
    step(1, 0, 2, 13, 1, 0, 0);
    chk_val("s5_err_idx", int'(o_protocol_err), 1);
    idle();
    chk_val("s5_err_sticky", int'(o_protocol_err), 1);
    chk_val("s5_no_cdb", int'(o_cdb_valid), 0);

    // Flush with an in-flight MULT and a simultaneous issue
    do_reset();
    step(1, 1, 0, 20, 1, 0, 0);
    idle();
    step(1, 0, 0, 30, 1, 1, 0);
    chk_val("s6_flush_infl", int'(o_inflight), 0);
    step(1, 1, 0, 21, 1, 0, 0);
    chk_val("s6_reissue_err", int'(o_protocol_err), 0);
    chk_val("s6_reissue_infl", int'(o_inflight), 1);
    for (int k = 0; k < 6; k++) idle();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 5), $urandom_range(0, 2),
           $urandom_range(0, 63), $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
    end
    for (int k = 0; k < 10; k++) idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
